// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: load handshake between a requester (master) and the counter (slave)
interface count_seq_ctrl_if;
    logic        load_req;
    logic [31:0] value;
    logic        load_ack;
    modport master (output load_req, value, input load_ack);
    modport slave (input load_req, value, output load_ack);
endinterface

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: loadable run/pause counter with wrap at LIMIT and a one-cycle load handshake
module count_seq_ctrl #(
    parameter logic [31:0] STEP  = 32'd1,
    parameter logic [31:0] LIMIT = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        enable,
    count_seq_ctrl_if.slave ld,
    output logic [31:0] count,
    output logic [7:0]  led,
    output logic [1:0]  state,
    output logic        wrap,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;
    state_t      st, nxt;
    logic [31:0] cnt_nxt;
    logic [32:0] sum;
    logic        ack, ack_nxt, wrap_nxt, run_step, over;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st    <= IDLE;
            count <= 32'd0;
            ack   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            st    <= nxt;
            count <= cnt_nxt;
            ack   <= ack_nxt;
            wrap  <= wrap_nxt;
        end
    end
    always_comb begin
        nxt = IDLE;
        if (!clr) begin
            case (st)
                IDLE, PAUSE: nxt = ld.load_req ? LOAD : enable ? RUN : st;
                LOAD:        nxt = enable ? RUN : IDLE;
                RUN:         nxt = ld.load_req ? LOAD : enable ? RUN : PAUSE;
                default:     nxt = IDLE;
            endcase
        end
    end
    // 33-bit sum avoids overflow; sum > LIMIT is equivalent to count > LIMIT-STEP
    always_comb begin
        sum      = {1'b0, count} + {1'b0, STEP};
        over     = sum > {1'b0, LIMIT};
        run_step = !clr && st == RUN && !ld.load_req && enable;
        cnt_nxt  = clr ? 32'd0 : st == LOAD ? ld.value :
                   run_step ? (over ? 32'd0 : sum[31:0]) : count;
        wrap_nxt = run_step && over;
        ack_nxt  = nxt == LOAD;
    end
    assign ld.load_ack = ack;
    assign busy        = st == LOAD || st == RUN;
    assign led         = count[23:16];
    assign state       = st;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: vector table, corner sequences and randomized run against a rule-level model
module tb_count_seq_ctrl;
    logic        CLK = 0, RST_N = 0, clr = 0, enable = 0, lr = 0;
    logic [31:0] value = 0;
    logic [31:0] c0, c1;
    logic [7:0]  led0, led1;
    logic [1:0]  st0, st1;
    logic        w0, w1, b0, b1;
    int          passed = 0, total = 0;

    count_seq_ctrl_if if0();
    count_seq_ctrl_if if1();
    assign if0.load_req = lr;
    assign if0.value    = value;
    assign if1.load_req = lr;
    assign if1.value    = value;

    count_seq_ctrl u0 (.CLK(CLK), .RST_N(RST_N), .clr(clr), .enable(enable), .ld(if0.slave),
                       .count(c0), .led(led0), .state(st0), .wrap(w0), .busy(b0));
    count_seq_ctrl #(.STEP(32'd3), .LIMIT(32'd10)) u1 (.CLK(CLK), .RST_N(RST_N), .clr(clr),
                       .enable(enable), .ld(if1.slave), .count(c1), .led(led1), .state(st1),
                       .wrap(w1), .busy(b1));

    always #5 CLK = ~CLK;

    // model state: 0 idle, 1 load, 2 run, 3 pause
    longint unsigned lim[2] = '{64'hFFFF_FFFF, 64'd10};
    longint unsigned stp[2] = '{64'd1, 64'd3};
    longint unsigned mc[2];
    int              ms[2];
    bit              mw[2], ma[2];

    typedef struct {
        bit          clr, en, lr;
        logic [31:0] val, c;
        logic [1:0]  s;
        bit          a, w;
    } vec_t;
    vec_t tbl[20];

    function automatic logic [44:0] pk(logic [31:0] c, logic [1:0] s, logic a, logic w,
                                       logic b, logic [7:0] l);
        return {c, s, a, w, b, l};
    endfunction

    function automatic logic [44:0] exp_of(logic [31:0] c, logic [1:0] s, logic a, logic w);
        return pk(c, s, a, w, s == 2'd1 || s == 2'd2, c[23:16]);
    endfunction

    function logic [44:0] dut_out(int i);
        return i == 0 ? pk(c0, st0, if0.load_ack, w0, b0, led0)
                      : pk(c1, st1, if1.load_ack, w1, b1, led1);
    endfunction

    function automatic logic [44:0] model_out(int i);
        logic [31:0] c = mc[i][31:0];
        return exp_of(c, ms[i][1:0], ma[i], mw[i]);
    endfunction

    task automatic check(string name, logic [44:0] act, logic [44:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got {count,state,ack,wrap,busy,led}=%h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; ms[i] = 0; mw[i] = 0; ma[i] = 0;
        end
    endtask

    task automatic step_model();
        for (int i = 0; i < 2; i++) begin
            mw[i] = 0;
            ma[i] = 0;
            if (clr) begin
                ms[i] = 0; mc[i] = 0;
            end else if (ms[i] == 1) begin
                mc[i] = value; ms[i] = enable ? 2 : 0;
            end else if (lr) begin
                ms[i] = 1; ma[i] = 1;
            end else if (ms[i] == 2 && !enable) begin
                ms[i] = 3;
            end else if (ms[i] == 2) begin
                if (mc[i] + stp[i] > lim[i]) begin
                    mc[i] = 0; mw[i] = 1;
                end else mc[i] = mc[i] + stp[i];
            end else if (enable) begin
                ms[i] = 2;
            end
        end
    endtask

    task automatic drive(bit c, bit e, bit l, logic [31:0] v);
        clr = c; enable = e; lr = l; value = v;
    endtask

    task automatic cycle();
        @(posedge CLK);
        step_model();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        RST_N = 0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1;
    endtask

    initial begin
        tbl[0] = '{0, 1, 0, 0, 0, 2'd2, 0, 0};
        for (int i = 1; i < 8; i++) tbl[i] = '{0, 1, 0, 0, i, 2'd2, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 7, 2'd3, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 7, 2'd3, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 7, 2'd2, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 8, 2'd2, 0, 0};
        tbl[12] = '{1, 1, 1, 0, 0, 2'd0, 0, 0};
        tbl[13] = '{0, 0, 1, 32'h00AB_0000, 0, 2'd1, 1, 0};
        tbl[14] = '{0, 0, 0, 32'h00AB_0000, 32'h00AB_0000, 2'd0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 32'h00AB_0000, 2'd0, 0, 0};
        tbl[16] = '{0, 0, 1, 32'hFFFF_FFFF, 32'h00AB_0000, 2'd1, 1, 0};
        tbl[17] = '{0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 0, 0};
        tbl[18] = '{0, 1, 0, 0, 0, 2'd2, 0, 1};
        tbl[19] = '{0, 1, 0, 0, 1, 2'd2, 0, 0};

        do_reset();
        check("reset0", dut_out(0), exp_of(0, 0, 0, 0));
        check("reset1", dut_out(1), exp_of(0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].en, tbl[i].lr, tbl[i].val);
            cycle();
            check($sformatf("vec%0d", i), dut_out(0), exp_of(tbl[i].c, tbl[i].s, tbl[i].a, tbl[i].w));
        end

        // STEP=3, LIMIT=10: 0 (enter RUN), 3, 6, 9, 0 with wrap, 3
        do_reset();
        drive(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] e;
            e = (i == 4) ? 0 : (i == 5) ? 3 : 3 * i;
            cycle();
            check($sformatf("lim_seq%0d", i), dut_out(1), exp_of(e, 2'd2, 0, i == 4));
        end

        // value above LIMIT wraps on first RUN step; held load_req reloads after one gap cycle
        do_reset();
        drive(0, 0, 1, 32'd50);
        cycle();
        check("over_load", dut_out(1), exp_of(0, 1, 1, 0));
        cycle();
        check("held_req_gap", dut_out(1), exp_of(50, 0, 0, 0));
        cycle();
        check("held_req_reload", dut_out(1), exp_of(50, 1, 1, 0));
        drive(0, 1, 0, 32'd50);
        cycle();
        check("over_run", dut_out(1), exp_of(50, 2, 0, 0));
        cycle();
        check("over_wrap", dut_out(1), exp_of(0, 2, 0, 1));

        // asynchronous reset mid-RUN, between edges
        do_reset();
        drive(0, 1, 0, 0);
        repeat (4) cycle();
        check("pre_async", dut_out(0), exp_of(3, 2, 0, 0));
        #2 RST_N = 0;
        #1 check("async0", dut_out(0), exp_of(0, 0, 0, 0));
        check("async1", dut_out(1), exp_of(0, 0, 0, 0));
        @(negedge CLK);
        RST_N = 1;
        model_reset();
        cycle();
        check("post_async", dut_out(0), model_out(0));

        // reset during LOAD aborts it
        do_reset();
        drive(0, 0, 1, 32'h1234);
        cycle();
        #2 RST_N = 0;
        #1 check("load_abort", dut_out(0), exp_of(0, 0, 0, 0));
        @(negedge CLK);
        drive(0, 0, 0, 32'h1234);
        RST_N = 1;
        model_reset();
        cycle();
        check("load_abort_after", dut_out(0), model_out(0));

        do_reset();
        for (int n = 0; n < 500; n++) begin
            logic [31:0] v;
            case ($urandom % 4)
                0: v = $urandom % 16;
                1: v = 32'hFFFF_FFF0 | ($urandom % 16);
                2: v = $urandom;
                default: v = 8 + $urandom % 8;
            endcase
            drive($urandom % 25 == 0, $urandom % 4 != 0, $urandom % 6 == 0, v);
            cycle();
            check($sformatf("rand0_%0d", n), dut_out(0), model_out(0));
            check($sformatf("rand1_%0d", n), dut_out(1), model_out(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
